cmp_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit magnitude-compare datapath between `N_REQ` independent requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers its operands, runs the shared compare core, and returns the 2-bit result to the granted requester with a valid/ready response handshake. It sits between the requesting control blocks and the compare datapath, so that datapath never needs duplicating.

---
 rtl/cmp_pkg.sv | 15 +
 rtl/cmp_core.sv | 31 +++
 rtl/cmp_arbiter.sv | 116 +++++++++++
 tb/tb_cmp_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared encodings for the compare arbiter: result codes and sequencer states.
// No logic; imported by cmp_core and cmp_arbiter.
package cmp_pkg;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_LT = 2'b01;
    localparam logic [1:0] CMP_GT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/cmp_core.sv
// Purpose: WIDTH-bit magnitude compare, signed when CMP_ARB_SIGNED_EN is defined.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the result.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [1:0]       result
);

    always_comb begin
        result = CMP_EQ;
`ifdef CMP_ARB_SIGNED_EN
        if ($signed(a) < $signed(b)) begin
            result = CMP_LT;
        end else if ($signed(a) > $signed(b)) begin
            result = CMP_GT;
        end
`else
        if (a < b) begin
            result = CMP_LT;
        end else if (a > b) begin
            result = CMP_GT;
        end
`endif
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Purpose: round-robin share of one cmp_core among N_REQ requesters (signedness via CMP_ARB_SIGNED_EN).
// Latency: accept in IDLE, register result in CMP, hold response in RESP; 3 cycles minimum per op.
// Backpressure: RESP holds until rsp_ready; no grants are made outside IDLE.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [1:0]             rsp_result,
    input  logic                   rsp_ready,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand;
    logic             sel_vld;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [1:0]       core_res;

    cmp_core #(.WIDTH(WIDTH)) u_core (
        .a      (op_a),
        .b      (op_b),
        .result (core_res)
    );

    // First requesting index at or after rr_ptr, wrapping.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(rr_ptr) + k) % N_REQ);
            if (!sel_vld && req_valid[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = '0;
        case (state)
            ST_IDLE: begin
                if (sel_vld) begin
                    req_ready[sel_idx] = 1'b1;
                    state_nxt          = ST_CMP;
                end
            end
            ST_CMP: begin
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[gnt_idx] = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            gnt_idx    <= '0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_result <= CMP_EQ;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (sel_vld) begin
                        op_a    <= req_a[sel_idx*WIDTH +: WIDTH];
                        op_b    <= req_b[sel_idx*WIDTH +: WIDTH];
                        gnt_idx <= sel_idx;
                    end
                end
                ST_CMP: begin
                    rsp_result <= core_res;
                end
                ST_RESP: begin
                    // Pointer only advances once the response is consumed.
                    if (rsp_ready) begin
                        rr_ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: per-scenario tasks plus a scoreboard monitor
// that predicts grant order and results and matches them against responses.
module tb_cmp_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [1:0]     rsp_result;
    logic           rsp_ready;
    logic           busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         idx;
        logic [1:0] res;
    } exp_t;

    exp_t sb[$];
    int   model_ptr = 0;
    int   mon_exp;
    int   mon_act;

    always #5 clk = ~clk;

    cmp_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    function automatic logic [1:0] model_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef CMP_ARB_SIGNED_EN
        if ($signed(a) < $signed(b)) return 2'b01;
        if ($signed(a) > $signed(b)) return 2'b10;
`else
        if (a < b) return 2'b01;
        if (a > b) return 2'b10;
`endif
        return 2'b00;
    endfunction

    // Scoreboard monitor: predicts each grant, pushes the expected result, pops on response.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            model_ptr = 0;
        end else begin
            checks++;
            if ($countones(req_ready) > 1)
                $display("FAIL onehot_ready: req_ready=%b, required at most one bit", req_ready);
            if (|(req_valid & req_ready)) begin
                mon_exp = -1;
                mon_act = -1;
                for (int k = 0; k < N; k++)
                    if (mon_exp < 0 && req_valid[(model_ptr + k) % N]) mon_exp = (model_ptr + k) % N;
                for (int i = 0; i < N; i++)
                    if (req_ready[i] && mon_act < 0) mon_act = i;
                checks++;
                if (mon_act != mon_exp) begin
                    errors++;
                    $display("FAIL grant_order: granted=%0d required=%0d", mon_act, mon_exp);
                end
                checks++;
                if (sb.size() != 0) begin
                    errors++;
                    $display("FAIL grant_while_busy: grant=%0d with %0d pending, required 0", mon_act, sb.size());
                end
                sb.push_back('{mon_act, model_cmp(req_a[mon_act*W +: W], req_b[mon_act*W +: W])});
            end
            if (rsp_valid != '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_rsp: rsp_valid=%b with nothing pending, required 0000", rsp_valid);
                end else begin
                    if (rsp_valid !== N'(1 << sb[0].idx) || rsp_result !== sb[0].res) begin
                        errors++;
                        $display("FAIL sb_rsp: rsp_valid=%b result=%b required valid=%b result=%b",
                                 rsp_valid, rsp_result, N'(1 << sb[0].idx), sb[0].res);
                    end
                    if (rsp_ready) begin
                        model_ptr = (sb[0].idx + 1) % N;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[idx]    = 1'b1;
        req_a[idx*W +: W] = a;
        req_b[idx*W +: W] = b;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b required 0000", req_ready); end
        checks++;
        if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b required 0000", rsp_valid); end
        checks++;
        if (rsp_result !== 2'b00) begin errors++; $display("FAIL reset_rsp_result: got %b required 00", rsp_result); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        tick();
        rsp_ready = 1'b1;
        set_req(0, 8'd4, 8'd5);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: req_ready=%b required 0001", req_ready); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: busy=%b required 0", busy); end
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL single_cmp: busy=%b rsp_valid=%b required 1 / 0000", busy, rsp_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_result !== 2'b01) begin
            errors++; $display("FAIL single_rsp: rsp_valid=%b result=%b required 0001 / 01", rsp_valid, rsp_result);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_back_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        int t0 = -1;
        int t1 = -1;
        int n_rsp = 0;
        logic [1:0] r0 = 2'b11;
        logic [1:0] r1 = 2'b11;
        tick();
        rsp_ready = 1'b1;
        set_req(2, 8'd9, 8'd9);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready[2] && req_valid[2]) begin
                if (t0 < 0) t0 = c;
                else if (t1 < 0) t1 = c;
            end
            if (rsp_valid[2]) begin
                if (n_rsp == 0) r0 = rsp_result;
                else if (n_rsp == 1) r1 = rsp_result;
                n_rsp++;
            end
            tick();
            if (c == t0) begin
                req_a[2*W +: W] = 8'd10;
                req_b[2*W +: W] = 8'd8;
            end
            if (c == t1) req_valid[2] = 1'b0;
        end
        checks++;
        if (t0 < 0 || t1 < 0 || t1 - t0 != 3) begin
            errors++; $display("FAIL b2b_spacing: accepts at %0d,%0d required 3 apart", t0, t1);
        end
        checks++;
        if (n_rsp != 2) begin errors++; $display("FAIL b2b_count: responses=%0d required 2", n_rsp); end
        checks++;
        if (r0 !== 2'b00) begin errors++; $display("FAIL b2b_eq: result=%b required 00", r0); end
        checks++;
        if (r1 !== 2'b10) begin errors++; $display("FAIL b2b_gt: result=%b required 10", r1); end
    endtask

    task automatic test_all_valid();
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, W'(i * 7), W'(10));
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== ~|req_ready) begin
                errors++; $display("FAIL all_busy: busy=%b req_ready=%b required busy low only when granting", busy, req_ready);
            end
            for (int i = 0; i < N; i++) if (req_ready[i]) order.push_back(i);
            if (order.size() >= 5) break;
            tick();
        end
        tick();
        req_valid = '0;
        repeat (3) tick();
        checks++;
        if (order.size() != 5) begin
            errors++; $display("FAIL all_grant_count: grants=%0d required 5", order.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    errors++; $display("FAIL all_order: grant %0d went to %0d required %0d", i, order[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int got = 0;
        logic [N-1:0] next_gnt = '0;
        rsp_ready = 1'b0;
        set_req(1, 8'h20, 8'h30);
        set_req(3, 8'h40, 8'h10);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin got = 1; break; end
            tick();
        end
        checks++;
        if (!got) begin errors++; $display("FAIL stall_timeout: no response within 10 cycles, required one"); end
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_result !== 2'b01 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_hold: valid=%b result=%b ready=%b required 0010 / 01 / 0000",
                         rsp_valid, rsp_result, req_ready);
            end
        end
        tick();
        rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin next_gnt = req_ready; break; end
            tick();
        end
        checks++;
        if (next_gnt !== 4'b1000) begin
            errors++; $display("FAIL stall_next_grant: req_ready=%b required 1000", next_gnt);
        end
        tick();
        req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        set_req(1, 8'd1, 8'd2);
        @(negedge clk);
        tick();
        req_valid = '0;
        repeat (3) tick();
        set_req(2, 8'd3, 8'd3);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_pre_grant: req_ready=%b required 0100", req_ready); end
        tick();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || rsp_valid !== 4'b0000 || req_ready !== 4'b0000 || rsp_result !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b valid=%b ready=%b result=%b required 0 / 0000 / 0000 / 00",
                     busy, rsp_valid, req_ready, rsp_result);
        end
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
                errors++; $display("FAIL mid_no_rsp: rsp_valid=%b busy=%b required 0000 / 0", rsp_valid, busy);
            end
            tick();
        end
        for (int i = 0; i < N; i++) set_req(i, 8'd0, 8'd0);
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: req_ready=%b required 0001", req_ready); end
        tick();
        req_valid = '0;
        repeat (3) tick();
    endtask

    task automatic test_sign();
        int got = 0;
        logic [1:0] expv;
`ifdef CMP_ARB_SIGNED_EN
        expv = 2'b01;
`else
        expv = 2'b10;
`endif
        rsp_ready = 1'b1;
        set_req(0, 8'hFF, 8'h01);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                got = 1;
                checks++;
                if (rsp_result !== expv) begin
                    errors++; $display("FAIL sign_cmp: result=%b required %b", rsp_result, expv);
                end
                break;
            end
            tick();
            req_valid = '0;
        end
        checks++;
        if (!got) begin errors++; $display("FAIL sign_timeout: no response within 10 cycles, required one"); end
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_all_valid();
        test_stall();
        test_reset_mid();
        test_sign();
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
